// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: edge transmitter for an output-stationary NxN PE array.
// Accepts one N-lane operand vector per inner-dimension step, delays lane i by
// i cycles so operands meet diagonally inside the array, then zero-flushes the
// array and pulses done once every PE sum is final. A clear pulse to the array
// precedes each job.
// Optional build macro: SKEW_FEEDER_STATS_EN enables the stall_cnt bubble counter;
// without it stall_cnt is tied to zero.
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int KW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            in_valid,
  input  logic [N*DW-1:0] in_data,
  output logic            in_ready,
  output logic [N*DW-1:0] edge_out,
  output logic            array_clr,
  output logic            busy,
  output logic            done,
  output logic [15:0]     stall_cnt
);

  // Flush must run 2N cycles: N-1 cycles of skew plus N-1 hops across the
  // array plus margin for the last accumulate.
  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] F_LAST = FW'(2 * N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [KW-1:0] k_reg_r;
  logic [KW-1:0] k_cnt_r;
  logic [FW-1:0] f_cnt_r;
  logic          accept_s;
  logic          last_s;
  logic          ready_s;
  logic          clr_s;
  logic          busy_s;
  logic          done_s;

  // A vector is taken only while streaming; in_ready is high exactly then.
  assign accept_s = (state_r == S_STREAM) && in_valid;
  assign last_s   = accept_s && ((k_cnt_r + KW'(1)) == k_reg_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_CLEAR;
        else       state_s = S_IDLE;
      end
      S_CLEAR: begin
        if (k_reg_r != {KW{1'b0}}) state_s = S_STREAM;
        else                       state_s = S_FLUSH;
      end
      S_STREAM: begin
        if (last_s) state_s = S_FLUSH;
        else        state_s = S_STREAM;
      end
      S_FLUSH: begin
        if (f_cnt_r == F_LAST) state_s = S_FLUSH == S_FLUSH ? S_DONE : S_DONE;
        else                   state_s = S_FLUSH;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    ready_s = 1'b0;
    clr_s   = 1'b0;
    busy_s  = 1'b1;
    done_s  = 1'b0;
    case (state_s)
      S_IDLE:   busy_s  = 1'b0;
      S_CLEAR:  clr_s   = 1'b1;
      S_STREAM: ready_s = 1'b1;
      S_FLUSH:  busy_s  = 1'b1;
      S_DONE:   done_s  = 1'b1;
      default:  busy_s  = 1'b0;
    endcase
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      array_clr <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      in_ready  <= ready_s;
      array_clr <= clr_s;
      busy      <= busy_s;
      done      <= done_s;
    end
  end

  // Job length capture, accepted-vector count and flush count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg_r <= {KW{1'b0}};
      k_cnt_r <= {KW{1'b0}};
      f_cnt_r <= {FW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) k_reg_r <= k_len;
        end
        S_CLEAR: begin
          k_cnt_r <= {KW{1'b0}};
          f_cnt_r <= {FW{1'b0}};
        end
        S_STREAM: begin
          if (accept_s) k_cnt_r <= k_cnt_r + KW'(1);
        end
        S_FLUSH: f_cnt_r <= f_cnt_r + FW'(1);
        default: f_cnt_r <= f_cnt_r;
      endcase
    end
  end

  // Lane g is a chain of g+1 registers; it shifts every cycle so that zeros
  // (bubbles, flush) follow real data through the skew.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [DW-1:0] pipe_r [0:g];
    logic [DW-1:0] lane_in_s;

    assign lane_in_s = accept_s ? in_data[g*DW +: DW] : {DW{1'b0}};

    // Skew shift register for this lane.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= g; s++) pipe_r[s] <= {DW{1'b0}};
      end else begin
        pipe_r[0] <= lane_in_s;
        for (int s = 1; s <= g; s++) pipe_r[s] <= pipe_r[s-1];
      end
    end

    assign edge_out[g*DW +: DW] = pipe_r[g];
  end

`ifdef SKEW_FEEDER_STATS_EN
  logic [15:0] stall_r;

  // Saturating count of streaming cycles that carried a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_r <= 16'h0000;
    end else if (state_r == S_CLEAR) begin
      stall_r <= 16'h0000;
    end else if ((state_r == S_STREAM) && !in_valid && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'h0001;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cnt = stall_r;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Testbench for systolic_skew_feeder: cycle table for a single-vector job,
// job-level sequences (timing, bubbles, back-to-back, ignored start, reset),
// and a row/column feeder pair driving a 4x4 output-stationary PE model.
module tb_systolic_skew_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int KW = 8;
  localparam int W  = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [W-1:0]  row_data = '0;
  logic [W-1:0]  col_data = '0;

  logic          in_ready, array_clr, busy, done;
  logic [W-1:0]  edge_out;
  logic [15:0]   stall_cnt;
  logic          c_ready, c_clr, c_busy, c_done;
  logic [W-1:0]  c_edge;
  logic [15:0]   c_stall;

  int errors = 0;
  int checks = 0;
  int exp_stall_bub;
  int snap [N][N];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.N(N), .DW(DW), .KW(KW)) u_row (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_data(row_data), .in_ready(in_ready), .edge_out(edge_out),
    .array_clr(array_clr), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  systolic_skew_feeder #(.N(N), .DW(DW), .KW(KW)) u_col (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_data(col_data), .in_ready(c_ready), .edge_out(c_edge),
    .array_clr(c_clr), .busy(c_busy), .done(c_done), .stall_cnt(c_stall)
  );

  // Output-stationary PE array model: A flows right, B flows down.
  logic signed [DW-1:0] a_in [N][N];
  logic signed [DW-1:0] b_in [N][N];
  logic signed [DW-1:0] a_r  [N][N];
  logic signed [DW-1:0] b_r  [N][N];
  int acc [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = edge_out[i*DW +: DW];
      b_in[0][i] = c_edge[i*DW +: DW];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_r[i][j-1];
        b_in[j][i] = b_r[j-1][i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_r[i][j] <= '0;
          b_r[i][j] <= '0;
          acc[i][j] <= 0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_r[i][j] <= a_in[i][j];
          b_r[i][j] <= b_in[i][j];
          if (array_clr) acc[i][j] <= 0;
          else acc[i][j] <= acc[i][j] + int'(a_in[i][j]) * int'(b_in[i][j]);
        end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Row vector k: identity columns for k<N, otherwise a filler pattern.
  function automatic logic [W-1:0] row_vec(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      v[i*DW +: DW] = (k < N) ? ((i == k) ? DW'(1) : DW'(0)) : DW'(k + i);
    return v;
  endfunction

  // Column vector k: B[k][j] = -4 + 4k + j.
  function automatic logic [W-1:0] col_vec(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(-4 + 4 * k + j);
    return v;
  endfunction

  // Runs one job; cycles counted from CLEAR entry to the cycle done is seen.
  task automatic run_job(input int k, input int bub_at, input int bub_n, input int start_at,
                         output int cyc, output int clr_n, output int rdy_n, output int busy_gap);
    int  sidx;
    int  aidx;
    bit  got;
    cyc = 0; clr_n = 0; rdy_n = 0; busy_gap = 0; sidx = 0; aidx = 0; got = 1'b0;
    start = 1'b1; k_len = KW'(k); in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (array_clr) clr_n++;
    if (!busy) busy_gap++;
    for (int n = 0; n < 2000 && !got; n++) begin
      in_valid = (sidx >= bub_at && sidx < bub_at + bub_n) ? 1'b0 : 1'b1;
      row_data = row_vec(aidx);
      col_data = col_vec(aidx);
      start    = (cyc == start_at);
      if (in_ready && in_valid) aidx++;
      if (in_ready) sidx++;
      @(posedge clk); #1;
      cyc++;
      if (array_clr) clr_n++;
      if (in_ready) rdy_n++;
      if (!busy) busy_gap++;
      if (done) begin
        got = 1'b1;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) snap[i][j] = acc[i][j];
      end
    end
    if (!got) cyc = -1;
    chk("col_done_lockstep", c_done, 1'b1);
    start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_done_idle", {busy, done, array_clr}, 3'b000);
  endtask

  typedef struct packed {
    logic          start;
    logic [KW-1:0] k;
    logic          vld;
    logic [W-1:0]  data;
    logic [W-1:0]  exp_edge;
    logic [3:0]    exp_flags;   // {in_ready, array_clr, busy, done}
  } vec_t;

  vec_t tbl [13];

  initial begin
    int cyc, clr_n, rdy_n, gap;

`ifdef SKEW_FEEDER_STATS_EN
    exp_stall_bub = 2;
`else
    exp_stall_bub = 0;
`endif

    tbl[0]  = '{1'b1, 8'd1, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0110};
    tbl[1]  = '{1'b0, 8'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b1010};
    tbl[2]  = '{1'b0, 8'd0, 1'b1, 32'h0403_0201, 32'h0000_0001, 4'b0010};
    tbl[3]  = '{1'b1, 8'd5, 1'b1, 32'hFFFF_FFFF, 32'h0000_0200, 4'b0010};
    tbl[4]  = '{1'b0, 8'd0, 1'b0, 32'h0000_0000, 32'h0003_0000, 4'b0010};
    tbl[5]  = '{1'b0, 8'd0, 1'b0, 32'h0000_0000, 32'h0400_0000, 4'b0010};
    tbl[6]  = '{1'b0, 8'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0010};
    tbl[7]  = '{1'b0, 8'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0010};
    tbl[8]  = '{1'b0, 8'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0010};
    tbl[9]  = '{1'b0, 8'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0010};
    tbl[10] = '{1'b0, 8'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0011};
    tbl[11] = '{1'b0, 8'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000};
    tbl[12] = '{1'b0, 8'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000};

    // Power-on reset, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_edge", edge_out, 32'h0);
    chk("rst_flags", {in_ready, array_clr, busy, done}, 4'b0000);
    chk("rst_stall", stall_cnt, 16'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Cycle table: k_len=1, skew of {4,3,2,1}, ignored start and idle valid.
    for (int r = 0; r < 13; r++) begin
      start = tbl[r].start; k_len = tbl[r].k; in_valid = tbl[r].vld; row_data = tbl[r].data;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_edge", r), edge_out, tbl[r].exp_edge);
      chk($sformatf("tbl%0d_flags", r), {in_ready, array_clr, busy, done}, tbl[r].exp_flags);
      chk($sformatf("tbl%0d_stall", r), stall_cnt, 16'h0);
    end
    start = 1'b0; in_valid = 1'b0;

    // k_len=3 continuous: done 1+3+8 after CLEAR entry.
    run_job(3, 99, 0, -1, cyc, clr_n, rdy_n, gap);
    chk("k3_cycles", cyc, 12);
    chk("k3_clr", clr_n, 1);
    chk("k3_ready", rdy_n, 3);
    chk("k3_busy_gap", gap, 0);

    // k_len=0, started in the cycle right after the previous done.
    run_job(0, 99, 0, -1, cyc, clr_n, rdy_n, gap);
    chk("k0_cycles", cyc, 9);
    chk("k0_clr", clr_n, 1);
    chk("k0_ready", rdy_n, 0);

    // Start asserted mid-job is ignored.
    run_job(3, 99, 0, 4, cyc, clr_n, rdy_n, gap);
    chk("ign_start_cycles", cyc, 12);
    chk("ign_start_clr", clr_n, 1);

    // Two bubbles: ready stays high, done two cycles later.
    run_job(3, 1, 2, -1, cyc, clr_n, rdy_n, gap);
    chk("bub_cycles", cyc, 14);
    chk("bub_ready", rdy_n, 5);
    chk("bub_stall", stall_cnt, exp_stall_bub);

    // Integration: A=identity, B=-4..11, with one lockstep bubble.
    run_job(4, 2, 1, -1, cyc, clr_n, rdy_n, gap);
    chk("int_cycles", cyc, 14);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("pe_%0d_%0d", i, j), snap[i][j], -4 + 4 * i + j);

    // Asynchronous reset mid-STREAM.
    start = 1'b1; k_len = 8'd5; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; row_data = 32'h8C7F_80FF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_edge", edge_out, 32'h0000_80FF);
    #3 rst = 1'b1;
    #1;
    chk("midrst_edge", edge_out, 32'h0);
    chk("midrst_flags", {in_ready, array_clr, busy, done}, 4'b0000);
    chk("midrst_stall", stall_cnt, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_idle", {busy, done, in_ready}, 3'b000);
    run_job(2, 99, 0, -1, cyc, clr_n, rdy_n, gap);
    chk("k2_after_rst", cyc, 11);

    // Largest k_len: counter reaches 255 without wrapping.
    run_job(255, 99, 0, -1, cyc, clr_n, rdy_n, gap);
    chk("k255_cycles", cyc, 264);
    chk("k255_ready", rdy_n, 255);
    chk("k255_stall", stall_cnt, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
